instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch stage feeding the cpu2 core's 32-bit `in` instruction input.
//   Holds the PC and a word-addressed instruction memory with synchronous read.
//   Presents one instruction per cycle, with its PC, using a valid/ready handshake.
//   Supports PC redirect (branch/jump) from the core, halt on ECALL, and misaligned-target fault.
// PARAMETERS
//   ADDR_W    8      word-address bits; memory depth = 2**ADDR_W words
//   RESET_PC  32'h0  fetch address after reset; must be 4-byte aligned
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous reset, active-high
//   ready        in   1   downstream accepts instr this cycle
//   redirect     in   1   load new fetch PC and flush the output
//   redirect_pc  in   32  new fetch byte address
//   wr_en        in   1   instruction memory write enable (loader/bench)
//   wr_addr      in   ADDR_W  word address for the write
//   wr_data      in   32  write data
//   instr        out  32  instruction word to the core
//   pc           out  32  byte address of instr
//   valid        out  1   instr/pc are meaningful
//   halted       out  1   ECALL accepted; fetch stopped
//   fault        out  1   redirect to a misaligned target; fetch stopped
// BEHAVIOUR
// - Reset (async): state=RUN, fetch_pc=RESET_PC, instr=32'h00000013 (NOP), pc=RESET_PC,
//   valid=0, halted=0, fault=0. Memory contents are not reset.
// - States: RUN, HALT, FAULT. HALT and FAULT are sticky. Only rst leaves them.
// - Memory index = fetch_pc[ADDR_W+1:2]. Addresses alias modulo 4*2**ADDR_W bytes.
// - The output register advances when (!valid || ready), i.e. `adv`.
// - RUN, adv, no redirect (update on the clock edge):
//     instr <= mem[idx]; pc <= fetch_pc; valid <= 1; fetch_pc <= fetch_pc + 4.
//   fetch_pc wraps 32'hFFFFFFFC -> 32'h0.
// - Latency: the first valid is asserted on the first edge after rst deasserts.
//   Throughput is one instruction per cycle while ready=1.
// - RUN, valid && !ready: instr, pc, valid and fetch_pc hold stable.
//   Data must not change while valid=1 and ready=0.
// - Redirect (RUN only) has priority over adv and over ready:
//     redirect_pc[1:0]==0: fetch_pc <= redirect_pc; valid <= 0 next cycle (flush).
//       The new target appears with valid=1 one cycle later. Penalty: 1 bubble.
//     redirect_pc[1:0]!=0: state <= FAULT; fault <= 1; valid <= 0.
// - Redirect in the same cycle as valid&&ready: the current instr counts as accepted,
//   then the output is flushed.
// - ECALL (32'h00000073) is presented normally.
//   When it is accepted (valid && ready, no redirect), the next state is HALT: valid <= 0, halted <= 1.
//   A redirect in that same cycle wins: no halt.
// - HALT/FAULT: valid=0. Redirect and ready are ignored. instr/pc hold their last values.
// - Write port is active in every state.
//   A write and a read of the same word in one cycle: the read returns the old data.
// - Reset mid-stream: outputs take reset values immediately (async), not at the next edge.
// TESTING
// 1. Load 0x06300F13, 0x01E02023, 0x00002F83, 0x00000073 at words 0..3; ready=1; release rst
//    -> valid=1 on edge 1; (pc,instr) = (0,06300F13), (4,01E02023), (8,00002F83), (C,00000073).
//    -> Then valid=0 and halted=1.
// 2. Same program, ready=0 for 3 cycles after the first valid
//    -> instr=06300F13, pc=0 held stable; it resumes with pc=4 once ready=1.
// 3. At pc=4 valid, pulse redirect with redirect_pc=0x0
//    -> next cycle valid=0; following cycle pc=0, instr=06300F13; no halt occurs.
// 4. redirect_pc=0x6 -> next cycle fault=1, valid=0; later redirect to 0x0 is ignored;
//    rst clears fault.
// 5. ADDR_W=2, no ECALL, redirect to 0xFFFFFFFC -> the next instrs come from pc=FFFFFFFC then pc=0,
//    with memory word 3 then word 0.
// 6. Assert rst asynchronously mid-stream, between clock edges
//    -> valid=0, instr=00000013, pc=RESET_PC before the next edge.
//    -> Refetch starts from RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with PC, synchronous-read memory and valid/ready output
// Redirect, ECALL halt and misaligned-target fault; HALT/FAULT are left only through rst.
module instr_fetch #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic              valid,
    output logic              halted,
    output logic              fault
);
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_e;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic [31:0] mem [2**ADDR_W];

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q;
    logic        valid_q, valid_d;
    logic        load;
    logic        adv;
    logic [ADDR_W-1:0] idx;

    assign idx = fetch_pc_q[ADDR_W+1:2];
    assign adv = !valid_q || ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        load       = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    if (redirect_pc[1:0] == 2'b00) begin
                        fetch_pc_d = redirect_pc;
                    end else begin
                        state_d = FAULT;
                    end
                end else if (valid_q && ready && instr_q == ECALL) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end else if (adv) begin
                    load       = 1'b1;
                    pc_d       = fetch_pc_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // The output instr register doubles as the memory read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            if (load) begin
                instr_q <= mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign instr  = instr_q;
    assign pc     = pc_q;
    assign valid  = valid_q;
    assign halted = (state_q == HALT);
    assign fault  = (state_q == FAULT);
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch (ADDR_W=8 and ADDR_W=2 instances)
module tb_instr_fetch;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, ready, redirect, wr_en;
    logic [31:0] redirect_pc, wr_data;
    logic [7:0]  wr_addr;
    logic [31:0] instr, pc;
    logic        valid, halted, fault;

    logic        rst2, ready2, redirect2, wr_en2;
    logic [31:0] redirect_pc2, wr_data2;
    logic [1:0]  wr_addr2;
    logic [31:0] instr2, pc2;
    logic        valid2, halted2, fault2;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] prog [4];
    logic [31:0] progb [4];

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .rst(rst), .ready(ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .instr(instr), .pc(pc), .valid(valid), .halted(halted), .fault(fault)
    );

    instr_fetch #(.ADDR_W(2), .RESET_PC(32'h0)) dut_b (
        .clk(clk), .rst(rst2), .ready(ready2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .instr(instr2), .pc(pc2), .valid(valid2), .halted(halted2), .fault(fault2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.pc = p;
        e.instr = i;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.pc = p;
        e.instr = i;
        qb.push_back(e);
    endtask

    task automatic push_prog_a();
        for (int i = 0; i < 4; i++) push_a(32'(i * 4), prog[i]);
    endtask

    task automatic wait_empty_a(input string name);
        int n = 0;
        while (qa.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(qa.size()), 32'd0);
    endtask

    task automatic wait_empty_b(input string name);
        int n = 0;
        while (qb.size() != 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 32'(qb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_a: got pc=%h instr=%h expected no output", pc, instr);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("pc_a", pc, e.pc);
                check("instr_a", instr, e.instr);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2 && valid2 && ready2) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_b: got pc=%h instr=%h expected no output", pc2, instr2);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("pc_b", pc2, e.pc);
                check("instr_b", instr2, e.instr);
            end
        end
    end

    initial begin
        prog[0] = 32'h06300F13; prog[1] = 32'h01E02023;
        prog[2] = 32'h00002F83; prog[3] = 32'h00000073;
        progb[0] = 32'hA0A0A0A0; progb[1] = 32'hA1A1A1A1;
        progb[2] = 32'hA2A2A2A2; progb[3] = 32'hA3A3A3A3;
        rst = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rst2 = 1'b1; ready2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", instr, 32'h00000013);
        check("rst_pc", pc, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Test 1: straight-line program ending in ECALL
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_addr = 8'(i); wr_data = prog[i];
            wr_en2 = 1'b1; wr_addr2 = 2'(i); wr_data2 = progb[i];
        end
        tick();
        wr_en = 1'b0; wr_en2 = 1'b0;
        push_prog_a();
        rst = 1'b0;
        tick();
        check("t1_first_valid", 32'(valid), 32'd1);
        wait_empty_a("t1_drain");
        tick();
        check("t1_valid_after_ecall", 32'(valid), 32'd0);
        check("t1_halted", 32'(halted), 32'd1);

        // Test 2: backpressure holds output stable
        rst = 1'b1; ready = 1'b0;
        tick();
        push_prog_a();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_valid", 32'(valid), 32'd1);
            check("t2_hold_pc", pc, 32'h0);
            check("t2_hold_instr", instr, 32'h06300F13);
            tick();
        end
        ready = 1'b1;
        wait_empty_a("t2_drain");
        tick();
        check("t2_halted", 32'(halted), 32'd1);

        // Test 3: redirect to 0 while pc=4 is presented
        rst = 1'b1;
        tick();
        push_a(32'h0, prog[0]); push_a(32'h4, prog[1]);
        push_prog_a();
        rst = 1'b0;
        tick();
        tick();
        check("t3_pc4_present", pc, 32'h4);
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        check("t3_bubble_valid", 32'(valid), 32'd0);
        check("t3_no_halt", 32'(halted), 32'd0);
        wait_empty_a("t3_drain");
        tick();
        check("t3_halted_at_end", 32'(halted), 32'd1);

        // Test 4: misaligned redirect faults; later redirect ignored
        rst = 1'b1;
        tick();
        push_a(32'h0, prog[0]);
        rst = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect = 1'b0;
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_fault_valid", 32'(valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect = 1'b0;
        tick(); tick();
        check("t4_fault_sticky", 32'(fault), 32'd1);
        check("t4_valid_stays_0", 32'(valid), 32'd0);
        check("t4_queue", 32'(qa.size()), 32'd0);
        rst = 1'b1;
        #1;
        check("t4_rst_clears_fault", 32'(fault), 32'd0);

        // Test 5: ADDR_W=2 aliasing and fetch_pc wrap
        ready2 = 1'b1;
        push_b(32'h0, progb[0]);
        push_b(32'hFFFFFFFC, progb[3]);
        push_b(32'h0, progb[0]);
        push_b(32'h4, progb[1]);
        @(posedge clk); #1;
        rst2 = 1'b0;
        tick();
        redirect2 = 1'b1; redirect_pc2 = 32'hFFFFFFFC;
        tick();
        redirect2 = 1'b0;
        check("t5_bubble_valid", 32'(valid2), 32'd0);
        wait_empty_b("t5_drain");
        ready2 = 1'b0;

        // Test 6: asynchronous reset mid-stream
        tick();
        push_a(32'h0, prog[0]); push_a(32'h4, prog[1]);
        rst = 1'b0;
        tick();
        tick();
        #6;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(valid), 32'd0);
        check("t6_async_instr", instr, 32'h00000013);
        check("t6_async_pc", pc, 32'h0);
        check("t6_queue", 32'(qa.size()), 32'd0);
        @(posedge clk); #1;
        push_prog_a();
        rst = 1'b0;
        wait_empty_a("t6_refetch_drain");
        tick();
        check("t6_halted", 32'(halted), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
